round_robin_arbiter_4: RTL and testbench

ROUND_ROBIN_ARBITER_4 -- requirements
Module: round_robin_arbiter_4

---
 rtl/arb_pkg.sv | 38 +++
 rtl/grant_decoder_2x4.sv | 27 ++
 rtl/round_robin_arbiter_4.sv | 126 ++++++++++++
 tb/tb_round_robin_arbiter_4.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the 4-requester round-robin arbiter:
//   NUM_REQ     - number of requesters (4)
//   IDX_W       - width of a requester index (2)
//   arb_state_t - arbiter FSM states (IDLE, GRANT)
//   rr_pick()   - first set request at or above a pointer, wrapping modulo 4
// -----------------------------------------------------------------------------
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Search starts at ptr and walks upward; the 2-bit index wraps 3->0 by
    // itself, so the modulo is free. Only called with a nonzero request.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] req,
        input logic [IDX_W-1:0]   ptr
    );
        logic [IDX_W-1:0] idx;
        logic             found;
        rr_pick = '0;
        found   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ptr + IDX_W'(k);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/grant_decoder_2x4.sv
// -----------------------------------------------------------------------------
// grant_decoder_2x4
// Combinational 2-to-4 decoder turning the registered grant index into the
// one-hot grant vector. Output is all-zero when the grant is not valid, so
// at most one bit can ever be set.
// Ports:
//   i_idx   [1:0] in  - grant index
//   i_valid       in  - grant index is meaningful
//   o_gnt   [3:0] out - one-hot grant, or zero
// -----------------------------------------------------------------------------
module grant_decoder_2x4
    import arb_pkg::*;
(
    input  logic [IDX_W-1:0]   i_idx,
    input  logic               i_valid,
    output logic [NUM_REQ-1:0] o_gnt
);

    always_comb begin
        // NOTE: default assignment first so every path drives o_gnt and no latch is inferred.
        o_gnt = '0;
        if (i_valid) begin
            o_gnt[i_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/round_robin_arbiter_4.sv
// -----------------------------------------------------------------------------
// round_robin_arbiter_4
// Four-requester round-robin arbiter with grant hold. A grant is issued one
// edge after a request is seen in IDLE, searching upward from a rotating
// pointer; it is then held for as long as the grantee keeps its request high.
// Releasing always costs one dead (IDLE) cycle before the next grant.
//
// Optional feature, macro ARB_TIMEOUT_EN: a hold counter forces a release
// (with a one-cycle timeout pulse) after MAX_HOLD grant cycles if another
// requester is waiting. Without the macro no counter exists and timeout is 0.
//
// Parameters:
//   MAX_HOLD  - max consecutive grant cycles before forced release (2..255)
// Ports:
//   clk            in  - clock, rising edge
//   rst_n          in  - asynchronous active-low reset
//   req      [3:0] in  - request lines, bit i = requester i
//   gnt      [3:0] out - one-hot grant, zero when idle
//   gnt_idx  [1:0] out - binary index of current grant (0 when idle)
//   gnt_valid      out - a grant is active
//   timeout        out - one-cycle pulse on a forced release
// -----------------------------------------------------------------------------
module round_robin_arbiter_4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid,
    output logic               timeout
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("round_robin_arbiter_4: MAX_HOLD must be in 2..255");
    end

    arb_state_t       r_state;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_idx;
    logic             r_valid;
    logic [IDX_W-1:0] w_pick;

    assign w_pick = rr_pick(req, r_ptr);

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] r_hold;
    logic       r_timeout;
    logic       w_others;

    // Someone other than the current grantee is asking.
    assign w_others = |(req & ~gnt);
    assign timeout  = r_timeout;
`else
    assign timeout  = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking (<=) assignments only; reset is async so outputs clear without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_idx     <= '0;
            r_valid   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            r_hold    <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_state <= GRANT;
                        r_idx   <= w_pick;
                        r_valid <= 1'b1;
                        r_ptr   <= w_pick + 2'd1;
`ifdef ARB_TIMEOUT_EN
                        r_hold  <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (!req[r_idx]) begin
                        r_state <= IDLE;
                        r_idx   <= '0;
                        r_valid <= 1'b0;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (r_hold == HOLD_LAST && w_others) begin
                        r_state   <= IDLE;
                        r_idx     <= '0;
                        r_valid   <= 1'b0;
                        r_timeout <= 1'b1;
                    end else if (r_hold != HOLD_LAST) begin
                        // Saturates at HOLD_LAST while nobody else waits.
                        r_hold <= r_hold + 8'd1;
                    end
`endif
                end
                default: begin
                    r_state <= IDLE;
                    r_idx   <= '0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign gnt_idx   = r_idx;
    assign gnt_valid = r_valid;

    grant_decoder_2x4 u_dec (
        .i_idx   (r_idx),
        .i_valid (r_valid),
        .o_gnt   (gnt)
    );

endmodule

// File: tb/tb_round_robin_arbiter_4.sv
// -----------------------------------------------------------------------------
// tb_round_robin_arbiter_4
// Scoreboard bench: the driver applies req on the falling edge, advances a
// behavioural model of the arbitration rules and queues the expected
// {gnt, gnt_idx, gnt_valid, timeout} for the following rising edge; a monitor
// pops and compares shortly after each rising edge. Compile with
// +define+ARB_TIMEOUT_EN to exercise the hold timeout (MAX_HOLD = 4).
// -----------------------------------------------------------------------------
module tb_round_robin_arbiter_4;

    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    // Expected vector layout: {gnt[3:0], gnt_idx[1:0], gnt_valid, timeout}
    logic [7:0] exp_q[$];
    int         order_q[$];
    bit         rec_en = 1'b0;
    bit         prev_valid = 1'b0;

    // Reference model state: who owns the bus, where the next search starts,
    // how long the owner has held, and whether a forced release just happened.
    bit m_busy;
    int m_owner;
    int m_ptr;
    int m_hold;
    bit m_to;

    round_robin_arbiter_4 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, actual, expected);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_ptr   = 0;
        m_hold  = 0;
        m_to    = 1'b0;
    endtask

    // One rising edge of the arbitration rules, applied to request r.
    task automatic model_step(input logic [3:0] r);
        bit found;
        int i;
        m_to = 1'b0;
        if (!m_busy) begin
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
                i = (m_ptr + k) % 4;
                if (!found && r[i]) begin
                    found   = 1'b1;
                    m_busy  = 1'b1;
                    m_owner = i;
                    m_ptr   = (i + 1) % 4;
                    m_hold  = 0;
                end
            end
        end else if (!r[m_owner]) begin
            m_busy = 1'b0;
        end
`ifdef ARB_TIMEOUT_EN
        else if (m_hold == MAX_HOLD - 1 && (r & ~(4'b0001 << m_owner)) != 4'b0000) begin
            m_busy = 1'b0;
            m_to   = 1'b1;
        end else if (m_hold < MAX_HOLD - 1) begin
            m_hold++;
        end
`endif
    endtask

    function automatic logic [7:0] model_out();
        logic [3:0] g;
        logic [1:0] x;
        g = m_busy ? 4'(1 << m_owner) : 4'b0000;
        x = m_busy ? 2'(m_owner) : 2'd0;
        return {g, x, m_busy, m_to};
    endfunction

    task automatic push_step(input logic [3:0] r);
        model_step(r);
        exp_q.push_back(model_out());
    endtask

    task automatic drive(input logic [3:0] r);
        @(negedge clk);
        req = r;
        push_step(r);
    endtask

    // Assert reset between edges (3 ns after a rising edge), check outputs
    // clear without a clock, then release on a falling edge with first_req
    // already applied so the next rising edge is the first arbitration.
    task automatic reset_mid(input logic [3:0] first_req);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("reset_immediate", {gnt, gnt_idx, gnt_valid, timeout}, 8'h00);
        model_reset();
        prev_valid = 1'b0;
        @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        req   = first_req;
        push_step(first_req);
    endtask

    // Monitor: one expected entry per rising edge while the driver is active.
    initial begin
        logic [7:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("scoreboard{gnt,idx,valid,timeout}",
                      {gnt, gnt_idx, gnt_valid, timeout}, e);
                if (rec_en && gnt_valid && !prev_valid) order_q.push_back(int'(gnt_idx));
                prev_valid = gnt_valid;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] cur;
        int         exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};

        rst_n = 1'b0;
        req   = 4'b0000;
        model_reset();
        #3;
        check("reset_state", {gnt, gnt_idx, gnt_valid, timeout}, 8'h00);
        repeat (2) @(negedge clk);

        // Basic grant, release, dead cycle, next grant at index 2.
        rst_n = 1'b1;
        req   = 4'b0101;
        push_step(4'b0101);
        drive(4'b0101);
        drive(4'b0100);
        drive(4'b0100);
        drive(4'b0100);
        drive(4'b0000);

        // Grant requester 3, release, then requester 0: pointer wraps 3->0.
        drive(4'b1000);
        drive(4'b0000);
        drive(4'b0001);
        drive(4'b0000);

        // Reset in the middle of a grant to requester 1, then fairness run.
        drive(4'b0010);
        drive(4'b0010);
        rec_en = 1'b1;
        reset_mid(4'b1111);
        drive(4'b1111);
        for (int g = 0; g < 4; g++) begin
            drive(4'b1111 & ~(4'b0001 << m_owner));
            drive(4'b1111);
            drive(4'b1111);
        end
        drive(4'b0000);
        drive(4'b0000);
        rec_en = 1'b0;
        check("grant_order_len", order_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < order_q.size()) check($sformatf("grant_order[%0d]", i), order_q[i], exp_order[i]);
        end

        // Contended hold: forced release when the timeout is built in.
        reset_mid(4'b0000);
        for (int i = 0; i < 12; i++) drive(4'b0011);
        drive(4'b0000);

        // Uncontended hold: never released, no timeout.
        reset_mid(4'b0000);
        for (int i = 0; i < 20; i++) drive(4'b0001);
        drive(4'b0000);

        // Random traffic: each request line toggles with probability 1/5.
        cur = 4'b0000;
        for (int c = 0; c < 400; c++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 4) == 0) cur[b] = ~cur[b];
            end
            drive(cur);
        end
        drive(4'b0000);
        drive(4'b0000);

        @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
